// File: rtl/rv_p4_pkg.sv
// Shared types and widths for the rv_p4 datapath.
// Holds cell-id width and the packet-buffer read arbiter state type.
package rv_p4_pkg;

    localparam int CELL_ID_W = 16;
    localparam int PB_DATA_W = 512;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } pb_arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pb_rd_arb_if.sv
// Lane-array and packet-buffer read bus seen by pb_rd_arb.
// master = lanes plus buffer side, slave = the arbiter.
interface pb_rd_arb_if
    import rv_p4_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]                lane_req_valid;
    logic [NUM_REQ-1:0][CELL_ID_W-1:0] lane_req_cell_id;
    logic [NUM_REQ-1:0]                lane_req_ready;
    logic [NUM_REQ-1:0]                lane_rsp_valid;
    logic [PB_DATA_W-1:0]              lane_rsp_data;
    logic [CELL_ID_W-1:0]              lane_rsp_next_cell_id;
    logic                              lane_rsp_eof;

    logic                              pb_req_valid;
    logic [CELL_ID_W-1:0]              pb_req_cell_id;
    logic                              pb_req_ready;
    logic                              pb_rsp_valid;
    logic [PB_DATA_W-1:0]              pb_rsp_data;
    logic [CELL_ID_W-1:0]              pb_rsp_next_cell_id;
    logic                              pb_rsp_eof;

    modport master (
        output lane_req_valid,
        output lane_req_cell_id,
        input  lane_req_ready,
        input  lane_rsp_valid,
        input  lane_rsp_data,
        input  lane_rsp_next_cell_id,
        input  lane_rsp_eof,
        input  pb_req_valid,
        input  pb_req_cell_id,
        output pb_req_ready,
        output pb_rsp_valid,
        output pb_rsp_data,
        output pb_rsp_next_cell_id,
        output pb_rsp_eof
    );

    modport slave (
        input  lane_req_valid,
        input  lane_req_cell_id,
        output lane_req_ready,
        output lane_rsp_valid,
        output lane_rsp_data,
        output lane_rsp_next_cell_id,
        output lane_rsp_eof,
        output pb_req_valid,
        output pb_req_cell_id,
        input  pb_req_ready,
        input  pb_rsp_valid,
        input  pb_rsp_data,
        input  pb_rsp_next_cell_id,
        input  pb_rsp_eof
    );

endinterface

// File: rtl/pb_rd_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit
// searching upward from last+1, wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Walk from the farthest candidate back so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pb_rd_arb.sv
// Packet-level round-robin owner of the packet-buffer read port.
// A lane keeps the port for its whole cell chain until EOF or watchdog.
module pb_rd_arb
    import rv_p4_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_OUTST = 2,
    parameter  int TIMEOUT   = 1024,
    localparam int IW        = idx_w(NUM_REQ)
) (
    input  logic          clk_dp,
    input  logic          rst_dp_n,
    pb_rd_arb_if.slave    bus,
    output logic [IW-1:0] owner_id,
    output logic          busy,
    output logic          err_timeout,
    output logic          err_orphan
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [OW-1:0] OMAX  = OW'(MAX_OUTST);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    pb_arb_state_e state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_grant;
    logic [OW-1:0] outst;
    logic [WW-1:0] wd_cnt;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          owned;
    logic          room;
    logic          rsp_eof;
    logic          acc;
    logic          wd_fire;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (bus.lane_req_valid),
        .last  (last_grant),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign owned   = (state == OWNED);
    assign room    = (outst < OMAX);
    assign rsp_eof = bus.pb_rsp_valid && bus.pb_rsp_eof;
    assign acc     = bus.pb_req_valid && bus.pb_req_ready;
    assign wd_fire = owned && !bus.pb_rsp_valid &&
                     (outst != '0) && (wd_cnt == WLAST);

    // The EOF cycle must not start another cell for the departing owner.
    always_comb begin
        bus.lane_req_ready = '0;
        bus.lane_rsp_valid = '0;
        bus.pb_req_valid   = 1'b0;
        bus.pb_req_cell_id = '0;
        if (owned) begin
            bus.pb_req_valid = bus.lane_req_valid[owner] &&
                               room && !rsp_eof;
            bus.pb_req_cell_id = bus.lane_req_cell_id[owner];
            bus.lane_req_ready[owner] = bus.pb_req_ready &&
                                        room && !rsp_eof;
            bus.lane_rsp_valid[owner] = bus.pb_rsp_valid;
        end
    end

    assign bus.lane_rsp_data         = bus.pb_rsp_data;
    assign bus.lane_rsp_next_cell_id = bus.pb_rsp_next_cell_id;
    assign bus.lane_rsp_eof          = bus.pb_rsp_eof;

    assign owner_id = owner;
    assign busy     = owned;

    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            state       <= IDLE;
            owner       <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
            outst       <= '0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            err_orphan  <= 1'b0;
        end else begin
            if (bus.pb_rsp_valid && !owned) begin
                err_orphan <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state      <= OWNED;
                        owner      <= pick_idx;
                        last_grant <= pick_idx;
                        wd_cnt     <= '0;
                    end
                end
                OWNED: begin
                    if (rsp_eof || wd_fire) begin
                        state  <= IDLE;
                        outst  <= '0;
                        wd_cnt <= '0;
                        if (wd_fire) begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        if (acc && !bus.pb_rsp_valid) begin
                            outst <= outst + 1'b1;
                        end else if (!acc && bus.pb_rsp_valid &&
                                     outst != '0) begin
                            outst <= outst - 1'b1;
                        end
                        if (bus.pb_rsp_valid || outst == '0) begin
                            wd_cnt <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_rd_arb.sv
// Directed bench for pb_rd_arb with a per-cycle reference model
// built from queues and round-robin search over lane indices.
module tb_pb_rd_arb;
    import rv_p4_pkg::*;

    localparam int NR = 4;
    localparam int MO = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pb_rd_arb_if #(.NUM_REQ(NR)) bus ();

    logic [1:0] owner_id;
    logic       busy;
    logic       err_timeout;
    logic       err_orphan;

    pb_rd_arb #(
        .NUM_REQ   (NR),
        .MAX_OUTST (MO),
        .TIMEOUT   (TO)
    ) dut (
        .clk_dp      (clk),
        .rst_dp_n    (rst_n),
        .bus         (bus),
        .owner_id    (owner_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_orphan  (err_orphan)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm,
                         input logic [511:0] act,
                         input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner -1 means nobody holds the port.
    int       m_owner;
    int       m_id;
    int       m_last;
    int       m_wd;
    int       m_q[$];
    bit       m_to;
    bit       m_or;
    bit       own, eofr, room, e_pv, acc, found;
    logic [3:0]  e_rdy, e_rv;
    logic [15:0] e_cid;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner = -1; m_id = 0; m_last = NR - 1; m_wd = 0;
            m_q.delete(); m_to = 0; m_or = 0;
        end else begin
            own   = (m_owner >= 0);
            eofr  = bus.pb_rsp_valid && bus.pb_rsp_eof;
            room  = own && (m_q.size() < MO);
            e_pv  = 0; e_rdy = '0; e_rv = '0; e_cid = '0;
            if (own) begin
                e_pv  = bus.lane_req_valid[m_owner] && room && !eofr;
                e_cid = bus.lane_req_cell_id[m_owner];
                if (bus.pb_req_ready && room && !eofr) e_rdy[m_owner] = 1;
                if (bus.pb_rsp_valid) e_rv[m_owner] = 1;
            end
            check("m_pb_req_valid", bus.pb_req_valid, e_pv);
            check("m_pb_req_cell_id", bus.pb_req_cell_id, e_cid);
            check("m_lane_req_ready", bus.lane_req_ready, e_rdy);
            check("m_lane_rsp_valid", bus.lane_rsp_valid, e_rv);
            check("m_busy", busy, own);
            check("m_owner_id", owner_id, m_id[1:0]);
            check("m_err_timeout", err_timeout, m_to);
            check("m_err_orphan", err_orphan, m_or);
            check("m_rsp_data", bus.lane_rsp_data, bus.pb_rsp_data);
            check("m_rsp_next", bus.lane_rsp_next_cell_id,
                  bus.pb_rsp_next_cell_id);
            check("m_rsp_eof", bus.lane_rsp_eof, bus.pb_rsp_eof);
            if (!own) begin
                if (bus.pb_rsp_valid) m_or = 1;
                found = 0;
                for (int k = 1; k <= NR; k++) begin
                    if (!found && bus.lane_req_valid[(m_last + k) % NR]) begin
                        found   = 1;
                        m_owner = (m_last + k) % NR;
                        m_last  = m_owner;
                        m_id    = m_owner;
                        m_wd    = 0;
                    end
                end
            end else begin
                acc = e_pv && bus.pb_req_ready;
                if (eofr) begin
                    m_owner = -1; m_q.delete(); m_wd = 0;
                end else if (bus.pb_rsp_valid) begin
                    if (!acc && m_q.size() > 0) void'(m_q.pop_front());
                    m_wd = 0;
                end else if (m_q.size() > 0 && m_wd == TO - 1) begin
                    m_to = 1; m_owner = -1; m_q.delete(); m_wd = 0;
                end else begin
                    m_wd = (m_q.size() > 0) ? m_wd + 1 : 0;
                    if (acc) m_q.push_back(int'(e_cid));
                end
            end
        end
    end

    int   exp_order[5] = '{0, 1, 2, 3, 0};
    logic seen[4];

    initial begin
        bus.lane_req_valid      = '0;
        bus.lane_req_cell_id    = '0;
        bus.pb_req_ready        = 1'b0;
        bus.pb_rsp_valid        = 1'b0;
        bus.pb_rsp_data         = '0;
        bus.pb_rsp_next_cell_id = '0;
        bus.pb_rsp_eof          = 1'b0;
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner_id, 2'd0);
        check("rst_err_to", err_timeout, 1'b0);
        check("rst_err_or", err_orphan, 1'b0);
        check("rst_pbv", bus.pb_req_valid, 1'b0);
        check("rst_rdy", bus.lane_req_ready, 4'b0000);
        rst_n = 1'b1;
        tick();

        // single lane
        bus.pb_req_ready = 1'b1;
        bus.lane_req_valid = 4'b0100;
        bus.lane_req_cell_id[2] = 16'd100;
        #1;
        check("t1_idle_rdy", bus.lane_req_ready, 4'b0000);
        check("t1_idle_pbv", bus.pb_req_valid, 1'b0);
        tick();
        check("t1_cell", bus.pb_req_cell_id, 16'd100);
        check("t1_pbv", bus.pb_req_valid, 1'b1);
        check("t1_owner", owner_id, 2'd2);
        check("t1_rdy", bus.lane_req_ready, 4'b0100);
        tick();
        bus.lane_req_valid = '0;
        bus.pb_rsp_valid = 1'b1;
        bus.pb_rsp_eof = 1'b1;
        bus.pb_rsp_data = {16{32'hdeadbeef}};
        bus.pb_rsp_next_cell_id = 16'h0abc;
        #1;
        check("t1_rsp_valid", bus.lane_rsp_valid, 4'b0100);
        check("t1_busy_eof", busy, 1'b1);
        tick();
        bus.pb_rsp_valid = 1'b0;
        bus.pb_rsp_eof = 1'b0;
        check("t1_busy_drop", busy, 1'b0);

        // fairness from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.lane_req_valid = 4'b1111;
        for (int i = 0; i < 4; i++)
            bus.lane_req_cell_id[i] = 16'(10 + i);
        for (int p = 0; p < 5; p++) begin
            tick();
            check($sformatf("fair_grant%0d", p), owner_id, exp_order[p]);
            if (p < 4) begin
                check("fair_unique", seen[owner_id], 1'b0);
                seen[owner_id] = 1'b1;
            end
            tick();
            bus.pb_rsp_valid = 1'b1;
            bus.pb_rsp_eof = 1'b1;
            tick();
            bus.pb_rsp_valid = 1'b0;
            bus.pb_rsp_eof = 1'b0;
        end

        // multi-cell chain 5 -> 9 -> 12, lane 3 waiting
        bus.lane_req_valid = 4'b1010;
        bus.lane_req_cell_id[1] = 16'd5;
        bus.lane_req_cell_id[3] = 16'd77;
        tick();
        check("mc_owner", owner_id, 2'd1);
        check("mc_cell5", bus.pb_req_cell_id, 16'd5);
        tick();
        bus.lane_req_cell_id[1] = 16'd9;
        #1;
        check("mc_cell9", bus.pb_req_cell_id, 16'd9);
        check("mc_rdy9", bus.lane_req_ready, 4'b0010);
        tick();
        bus.lane_req_cell_id[1] = 16'd12;
        #1;
        check("mc_full_pbv", bus.pb_req_valid, 1'b0);
        check("mc_full_rdy", bus.lane_req_ready, 4'b0000);
        tick();
        bus.pb_rsp_valid = 1'b1;
        bus.pb_rsp_next_cell_id = 16'd9;
        #1;
        check("mc_rsp5", bus.lane_rsp_valid, 4'b0010);
        check("mc_full_pbv2", bus.pb_req_valid, 1'b0);
        tick();
        bus.pb_rsp_next_cell_id = 16'd12;
        #1;
        check("mc_pbv12", bus.pb_req_valid, 1'b1);
        check("mc_rdy12", bus.lane_req_ready, 4'b0010);
        tick();
        bus.lane_req_valid = 4'b1000;
        bus.pb_rsp_eof = 1'b1;
        bus.pb_rsp_next_cell_id = 16'd0;
        #1;
        check("mc_eof_rdy", bus.lane_req_ready, 4'b0000);
        check("mc_eof_busy", busy, 1'b1);
        tick();
        bus.pb_rsp_valid = 1'b0;
        bus.pb_rsp_eof = 1'b0;
        bus.pb_req_ready = 1'b0;
        check("mc_release", busy, 1'b0);

        // backpressure on lane 3
        tick();
        check("bp_owner", owner_id, 2'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp_pbv", bus.pb_req_valid, 1'b1);
            check("bp_cell", bus.pb_req_cell_id, 16'd77);
            check("bp_rdy", bus.lane_req_ready, 4'b0000);
            if (i < 4) tick();
        end
        tick();
        bus.pb_req_ready = 1'b1;
        #1;
        check("bp_accept_rdy", bus.lane_req_ready, 4'b1000);

        // no response: watchdog releases 16 cycles after acceptance
        tick();
        bus.lane_req_valid = '0;
        for (int k = 1; k < TO; k++) begin
            tick();
            check($sformatf("to_busy%0d", k), busy, 1'b1);
        end
        tick();
        check("to_idle", busy, 1'b0);
        check("to_err", err_timeout, 1'b1);
        bus.lane_req_valid = 4'b0001;
        bus.lane_req_cell_id[0] = 16'd3;
        tick();
        check("to_next_owner", owner_id, 2'd0);
        check("to_next_busy", busy, 1'b1);
        tick();
        bus.lane_req_valid = '0;
        bus.pb_rsp_valid = 1'b1;
        bus.pb_rsp_eof = 1'b1;
        tick();
        bus.pb_rsp_valid = 1'b0;
        bus.pb_rsp_eof = 1'b0;

        // orphan response in IDLE
        bus.pb_rsp_valid = 1'b1;
        #1;
        check("or_rsp_valid", bus.lane_rsp_valid, 4'b0000);
        tick();
        bus.pb_rsp_valid = 1'b0;
        check("or_err", err_orphan, 1'b1);
        rst_n = 1'b0;
        #1;
        check("or_clr", err_orphan, 1'b0);
        check("to_clr", err_timeout, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pb_rd_arb.md
# pb_rd_arb

Packet-level round-robin arbiter that shares the single packet-buffer read port (pb_rd) among NUM_REQ deparser lanes. A lane is granted ownership for a whole packet, i.e. its complete cell chain. Each lane's cell requests are forwarded to the buffer, and responses are steered back to the owner. Ownership is released on the EOF response, or on a watchdog timeout. The block sits between the deparser lane array and the packet buffer read interface in the clk_dp domain.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8)
- MAX_OUTST, 2, max cell requests in flight to the buffer
- TIMEOUT, 1024, cycles allowed without a response while owned before forced release

Ports:
- clk_dp  in  1  datapath clock; all logic on rising edge
- rst_dp_n  in  1  asynchronous, active-low reset
- lane_req_valid  in  NUM_REQ  per-lane cell read request
- lane_req_cell_id  in  NUM_REQ x CELL_ID_W  per-lane requested cell
- lane_req_ready  out  NUM_REQ  per-lane accept
- lane_rsp_valid  out  NUM_REQ  response valid, only the owner bit set
- lane_rsp_data  out  512  response data, broadcast to all lanes
- lane_rsp_next_cell_id  out  CELL_ID_W  broadcast
- lane_rsp_eof  out  1  broadcast
- pb_req_valid  out  1  request to packet buffer
- pb_req_cell_id  out  CELL_ID_W  request cell id
- pb_req_ready  in  1  buffer accept
- pb_rsp_valid  in  1  buffer response
- pb_rsp_data  in  512  response data
- pb_rsp_next_cell_id  in  CELL_ID_W  chain pointer
- pb_rsp_eof  in  1  last cell of packet
- owner_id  out  $clog2(NUM_REQ)  current owner, status only
- busy  out  1  state == OWNED
- err_timeout  out  1  sticky, set on watchdog release
- err_orphan  out  1  sticky, set on response while IDLE

## Operation
- States: IDLE and OWNED. Registers: owner, last_grant, outst (0..MAX_OUTST), wd_cnt.
- IDLE: select the first asserted lane_req_valid, searching round-robin from last_grant+1 (mod NUM_REQ). On a hit, go to OWNED next cycle with owner = last_grant = the winner, and clear wd_cnt.
  - No request is forwarded in the arbitration cycle. All lane_req_ready are 0 in IDLE.
- OWNED forwarding:
  - pb_req_valid = lane_req_valid[owner] && outst < MAX_OUTST.
  - pb_req_cell_id = lane_req_cell_id[owner].
  - lane_req_ready[owner] = pb_req_ready && outst < MAX_OUTST. All other lanes' ready = 0.
- outst update: +1 on accepted request, −1 on pb_rsp_valid; both in the same cycle means no change. outst never exceeds MAX_OUTST and never goes below 0.
- Response routing: lane_rsp_valid[owner] = pb_rsp_valid in OWNED. The data, next_cell_id and eof fields are broadcast pass-through, purely combinational.
- Release on pb_rsp_valid && pb_rsp_eof in OWNED: go to IDLE next cycle. outst is cleared to 0 on release, regardless of its value.
  - No request from the owner is accepted in the EOF cycle: lane_req_ready[owner] is forced to 0 when pb_rsp_eof && pb_rsp_valid.
- Watchdog:
  - In OWNED with outst > 0, wd_cnt increments each cycle without pb_rsp_valid. It resets on any response and holds at 0 when outst == 0.
  - When wd_cnt reaches TIMEOUT−1: set err_timeout, release to IDLE, clear outst.
- Orphan response: pb_rsp_valid in IDLE sets err_orphan; the response is dropped and all lane_rsp_valid stay 0.
- Sticky error flags clear only on reset.

## Timing
- Reset values:
  - state = IDLE; owner = 0; last_grant = NUM_REQ−1, so lane 0 wins first.
  - outst = 0; wd_cnt = 0; all outputs 0.
- Latency:
  - Request to grant: 1 cycle.
  - Owned request to pb_req_valid: 0 cycles, combinational.
  - pb response to lane response: 0 cycles.
- Throughput: one accepted request per cycle while owned and outst < MAX_OUTST.
- Release to the next grant costs 1 IDLE cycle, so the minimum packet-to-packet gap is 1 cycle.
- A lane dropping lane_req_valid while owned keeps ownership; only EOF or timeout releases.
- Reset asserted mid-packet: immediate return to reset values; in-flight responses after reset are flagged as orphans.

## Structure
- CELL_ID_W comes from rv_p4_pkg.
- Add a pb_arb_state_e enum (IDLE, OWNED) to rv_p4_pkg.
- Sub-module rr_pick: combinational round-robin priority picker with inputs req vector and last grant, and outputs valid and index. It is reusable by the future TX port scheduler.

## Test plan
- Single lane: lane 2 requests cell 100; buffer returns one cell with EOF. Required: pb_req_cell_id = 100 in the cycle after the request; lane_rsp_valid = 0b0100; busy drops 1 cycle after EOF.
- Fairness: all 4 lanes request continuously with single-cell packets. Required: grants follow 0,1,2,3,0, and no lane is granted twice before every other lane has been granted once.
- Multi-cell chain: lane 1 owns a 3-cell packet with cells 5→9→12 and MAX_OUTST = 2. Required: at most 2 outstanding; lane 3's requests get ready = 0 throughout; release after the third response, which carries EOF.
- Backpressure: pb_req_ready held 0 for 5 cycles. Required: pb_req_valid and cell_id stay stable and lane_req_ready stays 0; acceptance occurs in the first cycle ready = 1.
- Timeout with TIMEOUT = 16: request accepted, no response. Required: err_timeout is set and state is IDLE exactly 16 cycles after acceptance; the next lane can then be granted.
- Orphan response: pb_rsp_valid pulsed in IDLE. Required: err_orphan = 1 and no lane_rsp_valid. Reset then clears err_orphan.
